// File: rtl/req_arbiter_pkg.sv
// ============================================================================
// req_arbiter_pkg : shared types and constants for the 4-way request arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package req_arbiter_pkg;

  localparam int NREQ = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_arbiter_if.sv
// ============================================================================
// req_arbiter_if : requester-side bundle of the arbiter (requests in, grant out)
// Rev 1.0
// ============================================================================
`default_nettype none

interface req_arbiter_if;

  logic [3:0] req;
  logic       mode;
  logic [3:0] grant;
  logic [1:0] code;
  logic       valid;
  logic       expired;

  modport master (
    output req,
    output mode,
    input  grant,
    input  code,
    input  valid,
    input  expired
  );

  modport slave (
    input  req,
    input  mode,
    output grant,
    output code,
    output valid,
    output expired
  );

endinterface

`default_nettype wire

// File: rtl/req_arbiter_rr_pick.sv
// ============================================================================
// req_arbiter_rr_pick : combinational winner select, fixed priority or round robin
// Rev 1.0
// ============================================================================
`default_nettype none

module req_arbiter_rr_pick
  import req_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       mode,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] offset;
  logic [3:0] rot;
  logic [1:0] rr_idx;
  logic [1:0] fx_idx;

  always_comb begin
    any    = |req;
    offset = last + 2'd1;
    rot    = '0;
    rr_idx = 2'd0;
    fx_idx = 2'd0;

    // rot[0] is the requester right after the last owner
    for (int i = 0; i < 4; i++) begin
      rot[i] = req[2'(offset + 2'(i))];
    end
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) rr_idx = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (req[i]) fx_idx = 2'(i);
    end

    if (mode == MODE_RR) win = 2'(rr_idx + offset);
    else                 win = fx_idx;
  end

endmodule

`default_nettype wire

// File: rtl/req_arbiter.sv
// ============================================================================
// req_arbiter : 4-requester arbiter with hold limit and one-cycle turnaround gap
// Rev 1.0
// ============================================================================
`default_nettype none

module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
)(
  input  logic          clk,
  input  logic          rst,
  req_arbiter_if.slave  bus
);

  state_t             state;
  logic [NREQ-1:0]    grant_q;
  logic [1:0]         code_q;
  logic               valid_q;
  logic               expired_q;
  logic [CNT_W-1:0]   hold_cnt;
  logic [1:0]         last;

  logic [1:0]         win;
  logic               any;
  logic               owner_req;
  logic               limit_hit;

  req_arbiter_rr_pick u_pick (
    .req  (bus.req),
    .last (last),
    .mode (bus.mode),
    .win  (win),
    .any  (any)
  );

  assign owner_req = bus.req[code_q];
  assign limit_hit = (hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      code_q    <= 2'd0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
      hold_cnt  <= '0;
      last      <= 2'd3;
    end else begin
      expired_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            state    <= ST_GRANT;
            grant_q  <= onehot(win);
            code_q   <= win;
            valid_q  <= 1'b1;
            hold_cnt <= CNT_W'(1);
            last     <= win;
          end
        end
        ST_GRANT: begin
          if (!owner_req || limit_hit) begin
            // Dropping to IDLE here is what creates the turnaround gap
            state     <= ST_IDLE;
            grant_q   <= '0;
            code_q    <= 2'd0;
            valid_q   <= 1'b0;
            hold_cnt  <= '0;
            expired_q <= owner_req;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          code_q  <= 2'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.expired = expired_q;

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter.sv
// ============================================================================
// tb_req_arbiter : directed self-checking bench for req_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_req_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  req_arbiter_if bus ();

  req_arbiter #(
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.mode = 1'b0;
    step();
    step();
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.valid !== 1'b0 || bus.expired !== 1'b0 || bus.code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b valid=%b exp=%b code=%0d, expected 0000/0/0/0",
               bus.grant, bus.valid, bus.expired, bus.code);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (bus.grant !== 4'b1000 || bus.code !== 2'd3 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b code=%0d valid=%b, expected 1000/3/1",
               bus.grant, bus.code, bus.valid);
    end
    bus.req = 4'b0000;
    step();
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.expired !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop_release: grant=%b exp=%b, expected 0000/0", bus.grant, bus.expired);
    end
    step();
  endtask

  task automatic test_fixed_handoff();
    bus.mode = 1'b0;
    bus.req  = 4'b0110;
    step();
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.code !== 2'd2) begin
      n_fail++;
      $display("FAIL fixed_pick: grant=%b code=%0d, expected 0100/2", bus.grant, bus.code);
    end
    bus.req = 4'b0010;
    step();
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.valid !== 1'b0 || bus.expired !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_gap: grant=%b valid=%b exp=%b, expected 0000/0/0",
               bus.grant, bus.valid, bus.expired);
    end
    step();
    n_tests++;
    if (bus.grant !== 4'b0010 || bus.code !== 2'd1 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff_next: grant=%b code=%0d valid=%b, expected 0010/1/1",
               bus.grant, bus.code, bus.valid);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_rr_rotation();
    logic [1:0] exp_code;
    logic [3:0] exp_grant;
    int         bad;
    do_reset();
    bus.mode = 1'b1;
    bus.req  = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      exp_code  = 2'(g % 4);
      exp_grant = 4'b0001 << (g % 4);
      n_tests++;
      if (bus.grant !== exp_grant || bus.code !== exp_code || bus.expired !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: grant=%b code=%0d exp=%b, expected %b/%0d/0",
                 g, bus.grant, bus.code, bus.expired, exp_grant, exp_code);
      end
      if (g == 4) break;
      bad = 0;
      for (int k = 1; k < 16; k++) begin
        step();
        if (bus.grant !== exp_grant || bus.valid !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rr_hold%0d: %0d cycles lost grant, expected 0", g, bad);
      end
      step();
      n_tests++;
      if (bus.valid !== 1'b0 || bus.grant !== 4'b0000 || bus.expired !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_expire%0d: valid=%b grant=%b exp=%b, expected 0/0000/1",
                 g, bus.valid, bus.grant, bus.expired);
      end
      step();
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_hold_limit();
    int first_run;
    int n_exp;
    int n_valid;
    logic run_open;
    logic ok_regrant;
    bus.mode   = 1'b0;
    bus.req    = 4'b0001;
    first_run  = 0;
    n_exp      = 0;
    n_valid    = 0;
    run_open   = 1'b1;
    ok_regrant = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (bus.valid === 1'b1) n_valid++;
      if (bus.expired === 1'b1) n_exp++;
      if (run_open && bus.valid === 1'b1) first_run++;
      if (s > 1 && bus.valid !== 1'b1) run_open = 1'b0;
      if (s == 18 && bus.grant === 4'b0001 && bus.code === 2'd0) ok_regrant = 1'b1;
    end
    n_tests++;
    if (first_run != 16) begin
      n_fail++;
      $display("FAIL hold_len: first grant lasted %0d cycles, expected 16", first_run);
    end
    n_tests++;
    if (n_exp != 2 || n_valid != 38) begin
      n_fail++;
      $display("FAIL hold_pattern: expired=%0d valid=%0d in 40 cycles, expected 2/38", n_exp, n_valid);
    end
    n_tests++;
    if (!ok_regrant) begin
      n_fail++;
      $display("FAIL hold_regrant: index 0 not regranted after one gap cycle, expected grant 0001");
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    bus.mode = 1'b0;
    bus.req  = 4'b0100;
    for (int k = 0; k < 7; k++) step();
    n_tests++;
    if (bus.grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_pre: grant=%b, expected 0100", bus.grant);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (bus.grant !== 4'b0000 || bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: grant=%b valid=%b, expected 0000/0", bus.grant, bus.valid);
    end
    rst      = 1'b0;
    bus.mode = 1'b1;
    bus.req  = 4'b1100;
    step();
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.code !== 2'd2) begin
      n_fail++;
      $display("FAIL midrst_rr: grant=%b code=%0d, expected 0100/2", bus.grant, bus.code);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_mode_change();
    int bad;
    bus.mode = 1'b0;
    bus.req  = 4'b0010;
    step();
    n_tests++;
    if (bus.grant !== 4'b0010 || bus.code !== 2'd1) begin
      n_fail++;
      $display("FAIL modechg_pre: grant=%b code=%0d, expected 0010/1", bus.grant, bus.code);
    end
    bad = 0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bus.mode = ~bus.mode;
      step();
      if (bus.grant !== 4'b0010 || bus.code !== 2'd1) bad++;
      if ((bus.grant & (bus.grant - 4'd1)) !== 4'b0000) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL modechg_hold: %0d bad cycles, expected owner 1 one-hot throughout", bad);
    end
    // mode ends at 1; fixed would pick 3, round robin from last=1 picks 2
    bus.req = 4'b1101;
    step();
    n_tests++;
    if (bus.valid !== 1'b0 || bus.expired !== 1'b0) begin
      n_fail++;
      $display("FAIL modechg_release: valid=%b exp=%b, expected 0/0", bus.valid, bus.expired);
    end
    step();
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.code !== 2'd2) begin
      n_fail++;
      $display("FAIL modechg_next: grant=%b code=%0d, expected 0100/2", bus.grant, bus.code);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.mode = 1'b0;
    test_reset();
    test_fixed_handoff();
    test_rr_rotation();
    test_hold_limit();
    test_reset_mid_grant();
    test_mode_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
